// File: rtl/msgpass_rqst_addr_gen.sv
// ---------------------------------------------------------------------------
// msgpass_rqst_addr_gen
// Read-address sequencer for the message-pass buffer. It walks a programmable
// window of buffer entries NUM_CH addresses per beat, wrapping at the end of
// the buffer. It freezes while the memShare controller flags a DRC conflict,
// can loop over the window until aborted, and idles for a few cycles before
// signalling completion so that reads already issued can land.
// ---------------------------------------------------------------------------
module msgpass_rqst_addr_gen #(
    parameter int NUM_CH       = 2,
    parameter int BUFF_DEPTH   = 32,
    parameter int ADDR_W       = $clog2(BUFF_DEPTH),
    parameter int DRC_NUM      = 2,
    parameter int DRAIN_CYCLES = 5,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [ADDR_W-1:0]          start_addr_i,
    input  logic [ADDR_W:0]            len_i,
    input  logic                       circ_mode_i,
    input  logic [DRC_NUM-1:0]         is_drc_i,
    output logic [NUM_CH*ADDR_W-1:0]   raddr_o,
    output logic [NUM_CH-1:0]          rvalid_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [STALL_CNT_W-1:0]     stall_cnt_o
);

    // Lengths need one more bit than addresses so a full-buffer window fits.
    localparam int LEN_W   = ADDR_W + 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [LEN_W-1:0]   DEPTH_LEN  = LEN_W'(BUFF_DEPTH);
    localparam logic [ADDR_W-1:0]  STEP_ADDR  = ADDR_W'(NUM_CH % BUFF_DEPTH);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Modular add for two in-range operands. The sum is below 2*BUFF_DEPTH,
    // so a single compare-and-subtract gives the correct result for any
    // depth, including non-power-of-two ones.
    function automatic logic [ADDR_W-1:0] modAdd(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
        logic [LEN_W-1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= DEPTH_LEN) begin
            sum = sum - DEPTH_LEN;
        end
        return sum[ADDR_W-1:0];
    endfunction

    // Per-channel addresses of a beat whose first entry is 'cur'.
    function automatic logic [NUM_CH*ADDR_W-1:0] beatAddr(input logic [ADDR_W-1:0] cur);
        logic [NUM_CH*ADDR_W-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            res[k*ADDR_W +: ADDR_W] = modAdd(cur, ADDR_W'(k % BUFF_DEPTH));
        end
        return res;
    endfunction

    // Channel k carries a real address only while k entries remain ahead of it.
    function automatic logic [NUM_CH-1:0] beatValid(input logic [LEN_W-1:0] rem);
        logic [NUM_CH-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            res[k] = (k < int'(rem));
        end
        return res;
    endfunction

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_cur;
    logic [LEN_W-1:0]          r_rem;
    logic [ADDR_W-1:0]         r_start;
    logic [LEN_W-1:0]          r_len;
    logic                      r_circ;
    logic [DRAIN_W-1:0]        r_drainCnt;
    logic [STALL_CNT_W-1:0]    r_stallCnt;
    logic [NUM_CH*ADDR_W-1:0]  r_raddr;
    logic [NUM_CH-1:0]         r_rvalid;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_drc;
    logic [LEN_W-1:0]          w_lenClamped;
    logic [ADDR_W-1:0]         w_startWrapped;
    logic [ADDR_W-1:0]         w_nextCur;
    logic [LEN_W-1:0]          w_nextRem;

    assign w_drc     = |is_drc_i;
    assign w_nextCur = modAdd(r_cur, STEP_ADDR);

    // Request decode and next-beat arithmetic shared by the state machine.
    always_comb begin
        w_lenClamped   = (len_i > DEPTH_LEN) ? DEPTH_LEN : len_i;
        w_startWrapped = start_addr_i;
        if ({1'b0, start_addr_i} >= DEPTH_LEN) begin
            w_startWrapped = ADDR_W'({1'b0, start_addr_i} - DEPTH_LEN);
        end
        w_nextRem = '0;
        if (int'(r_rem) > NUM_CH) begin
            w_nextRem = r_rem - LEN_W'(NUM_CH);
        end
    end

    // Sequencer: launches windows, advances or freezes beats, drains, signals done.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cur      <= '0;
            r_rem      <= '0;
            r_start    <= '0;
            r_len      <= '0;
            r_circ     <= 1'b0;
            r_drainCnt <= '0;
            r_stallCnt <= '0;
            r_raddr    <= '0;
            r_rvalid   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_start    <= w_startWrapped;
                        r_len      <= w_lenClamped;
                        r_circ     <= circ_mode_i;
                        r_stallCnt <= '0;
                        if (w_lenClamped == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RUN;
                            r_busy   <= 1'b1;
                            r_cur    <= w_startWrapped;
                            r_rem    <= w_lenClamped;
                            r_raddr  <= beatAddr(w_startWrapped);
                            r_rvalid <= beatValid(w_lenClamped);
                        end
                    end
                end

                RUN: begin
                    if (abort_i || (!w_drc && w_nextRem == '0 && !r_circ)) begin
                        r_rvalid   <= '0;
                        r_drainCnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (w_drc) begin
                        if (r_stallCnt != '1) begin
                            r_stallCnt <= r_stallCnt + 1'b1;
                        end
                    end else if (w_nextRem == '0) begin
                        r_cur    <= r_start;
                        r_rem    <= r_len;
                        r_raddr  <= beatAddr(r_start);
                        r_rvalid <= beatValid(r_len);
                    end else begin
                        r_cur    <= w_nextCur;
                        r_rem    <= w_nextRem;
                        r_raddr  <= beatAddr(w_nextCur);
                        r_rvalid <= beatValid(w_nextRem);
                    end
                end

                DRAIN: begin
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign raddr_o     = r_raddr;
    assign rvalid_o    = r_rvalid;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign stall_cnt_o = r_stallCnt;

endmodule

// File: tb/tb_msgpass_rqst_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_msgpass_rqst_addr_gen
// Builds the expected per-cycle output trace of each sequence from the window
// description (list of window entries, beat position, stall/abort events) and
// compares it against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_msgpass_rqst_addr_gen;

    localparam int NUM_CH  = 2;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int DRC_NUM = 2;
    localparam int DRAIN   = 5;
    localparam int STALL_W = 16;

    logic                      sys_clk = 1'b0;
    logic                      rst;
    logic                      start_i;
    logic                      abort_i;
    logic [ADDR_W-1:0]         start_addr_i;
    logic [ADDR_W:0]           len_i;
    logic                      circ_mode_i;
    logic [DRC_NUM-1:0]        is_drc_i;
    logic [NUM_CH*ADDR_W-1:0]  raddr_o;
    logic [NUM_CH-1:0]         rvalid_o;
    logic                      busy_o;
    logic                      done_o;
    logic [STALL_W-1:0]        stall_cnt_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [NUM_CH-1:0]             rv;
        logic [NUM_CH-1:0][ADDR_W-1:0] addr;
        logic                          busy;
        logic                          done;
        logic [STALL_W-1:0]            stall;
    } exp_t;

    exp_t             expQ[$];
    logic [DRC_NUM-1:0] drcSeq[$];

    msgpass_rqst_addr_gen #(
        .NUM_CH(NUM_CH),
        .BUFF_DEPTH(DEPTH),
        .DRC_NUM(DRC_NUM),
        .DRAIN_CYCLES(DRAIN),
        .STALL_CNT_W(STALL_W)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .start_i(start_i),
        .abort_i(abort_i),
        .start_addr_i(start_addr_i),
        .len_i(len_i),
        .circ_mode_i(circ_mode_i),
        .is_drc_i(is_drc_i),
        .raddr_o(raddr_o),
        .rvalid_o(rvalid_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .stall_cnt_o(stall_cnt_o)
    );

    // Free-running system clock.
    always #5 sys_clk = ~sys_clk;

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DRC_NUM-1:0] drcAt(input int c);
        return (c < drcSeq.size()) ? drcSeq[c] : '0;
    endfunction

    // Expected trace: cycle 0 is the cycle right after start_i is sampled.
    task automatic buildTrace(input int sa, input int len, input bit circ, input int abortAt);
        int   L;
        int   pos;
        int   c;
        int   stalls;
        bit   running;
        exp_t e;
        expQ.delete();
        L      = (len > DEPTH) ? DEPTH : len;
        stalls = 0;
        if (L > 0) begin
            pos     = 0;
            c       = 0;
            running = 1'b1;
            while (running) begin
                e       = '0;
                e.busy  = 1'b1;
                e.stall = STALL_W'(stalls);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (pos + k < L) begin
                        e.rv[k]   = 1'b1;
                        e.addr[k] = ADDR_W'((sa + pos + k) % DEPTH);
                    end
                end
                expQ.push_back(e);
                if (c == abortAt) begin
                    running = 1'b0;
                end else if (drcAt(c) != '0) begin
                    stalls++;
                end else begin
                    pos += NUM_CH;
                    if (pos >= L) begin
                        if (circ) pos = 0;
                        else      running = 1'b0;
                    end
                end
                c++;
                if (c > 400) running = 1'b0;
            end
            for (int d = 0; d < DRAIN; d++) begin
                e       = '0;
                e.busy  = 1'b1;
                e.stall = STALL_W'(stalls);
                expQ.push_back(e);
            end
        end
        e       = '0;
        e.done  = 1'b1;
        e.stall = STALL_W'(stalls);
        expQ.push_back(e);
        e       = '0;
        e.stall = STALL_W'(stalls);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        total++;
        assert (rvalid_o === e.rv) else begin
            bad++;
            $error("[TB] FAIL %s rvalid observed=%b expected=%b", tag, rvalid_o, e.rv);
        end
        total++;
        assert (busy_o === e.busy) else begin
            bad++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy_o, e.busy);
        end
        total++;
        assert (done_o === e.done) else begin
            bad++;
            $error("[TB] FAIL %s done observed=%b expected=%b", tag, done_o, e.done);
        end
        total++;
        assert (stall_cnt_o === e.stall) else begin
            bad++;
            $error("[TB] FAIL %s stall observed=%0d expected=%0d", tag, stall_cnt_o, e.stall);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (e.rv[k]) begin
                total++;
                assert (raddr_o[k*ADDR_W +: ADDR_W] === e.addr[k]) else begin
                    bad++;
                    $error("[TB] FAIL %s raddr[%0d] observed=%0d expected=%0d",
                           tag, k, raddr_o[k*ADDR_W +: ADDR_W], e.addr[k]);
                end
            end
        end
    endtask

    // ignAt: cycle index at which a stray start_i is pulsed (-2 = DONE cycle).
    task automatic applyStimulus(input string tag, input int sa, input int len, input bit circ,
                                 input int abortAt, input int ignAt, input bit startAbort);
        int ign;
        buildTrace(sa, len, circ, abortAt);
        ign = (ignAt == -2) ? expQ.size() - 2 : ignAt;
        @(negedge sys_clk);
        start_i      = 1'b1;
        start_addr_i = ADDR_W'(sa);
        len_i        = (ADDR_W+1)'(len);
        circ_mode_i  = circ;
        abort_i      = startAbort;
        is_drc_i     = '0;
        for (int c = 0; c < expQ.size(); c++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("%s c%0d", tag, c), expQ[c]);
            start_i = (c == ign) && (c < expQ.size() - 1);
            if (start_i) begin
                start_addr_i = ADDR_W'($urandom_range(0, DEPTH - 1));
                len_i        = (ADDR_W+1)'($urandom_range(1, DEPTH));
                circ_mode_i  = 1'($urandom_range(0, 1));
            end
            abort_i  = (c == abortAt);
            is_drc_i = drcAt(c);
        end
        start_i  = 1'b0;
        abort_i  = 1'b0;
        is_drc_i = '0;
    endtask

    initial begin
        exp_t zero;
        int   sa;
        int   len;
        bit   circ;
        int   ab;
        int   ign;
        zero         = '0;
        rst          = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        start_addr_i = '0;
        len_i        = '0;
        circ_mode_i  = 1'b0;
        is_drc_i     = '0;

        // Reset state.
        repeat (3) @(negedge sys_clk);
        checkOutput("reset", zero);
        total++;
        assert (raddr_o === '0) else begin
            bad++;
            $error("[TB] FAIL reset raddr observed=%h expected=0", raddr_o);
        end
        rst = 1'b0;
        @(negedge sys_clk);

        // Directed cases.
        drcSeq.delete();
        applyStimulus("basic", 0, 5, 1'b0, -1, -1, 1'b0);
        applyStimulus("wrap", 6, 4, 1'b0, -1, -1, 1'b0);
        drcSeq = '{2'b00, 2'b01};
        applyStimulus("drc1", 0, 4, 1'b0, -1, -1, 1'b0);
        drcSeq = '{2'b00, 2'b10, 2'b10, 2'b10};
        applyStimulus("drc3", 0, 4, 1'b0, -1, -1, 1'b0);
        drcSeq.delete();
        applyStimulus("circ", 2, 3, 1'b1, 5, -1, 1'b0);
        applyStimulus("len0", 3, 0, 1'b0, -1, -1, 1'b0);
        applyStimulus("len12", 0, 12, 1'b0, -1, -1, 1'b0);
        applyStimulus("startAbort", 5, 6, 1'b0, -1, -1, 1'b1);
        applyStimulus("ignBusy", 1, 6, 1'b0, -1, 1, 1'b0);
        applyStimulus("ignDone", 4, 3, 1'b0, -1, -2, 1'b0);
        applyStimulus("abortDrain", 0, 2, 1'b0, 3, -1, 1'b0);

        // Reset asserted during the second RUN beat.
        @(negedge sys_clk);
        start_i      = 1'b1;
        start_addr_i = '0;
        len_i        = 5;
        circ_mode_i  = 1'b0;
        @(negedge sys_clk);
        start_i = 1'b0;
        @(negedge sys_clk);
        rst = 1'b1;
        #1;
        checkOutput("rstMid", zero);
        total++;
        assert (raddr_o === '0) else begin
            bad++;
            $error("[TB] FAIL rstMid raddr observed=%h expected=0", raddr_o);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("postRst c%0d", c), zero);
        end
        applyStimulus("afterRst", 3, 7, 1'b0, -1, -1, 1'b0);

        // Randomized sequences.
        for (int n = 0; n < 30; n++) begin
            sa   = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 12);
            circ = 1'($urandom_range(0, 1));
            drcSeq.delete();
            for (int c = 0; c < 30; c++) begin
                drcSeq.push_back(($urandom_range(0, 3) == 0) ? DRC_NUM'($urandom_range(1, 3)) : '0);
            end
            if (circ) ab = $urandom_range(0, 15);
            else      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus($sformatf("rand%0d", n), sa, len, circ, ab, ign, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
